sccpu_memsys: RTL and testbench

- Memory-side responder for the single-cycle CPU core. It serves the core's instruction fetch (pc → inst) and data access (alu/data/wmem → mem) from one single-port word RAM.
- An internal FSM serialises fetch and data access and raises stall, which gates the core's state-commit clock enable (PC register and regfile write).
- Also provides a host preload port for filling program and data memory before execution.

---
 rtl/sccpu_memsys_if.sv | 33 +++
 rtl/sccpu_memsys.sv | 145 ++++++++++++++
 tb/tb_sccpu_memsys.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sccpu_memsys_if.sv
// sccpu_memsys_if
// Bus between the single-cycle CPU core and its memory responder.
// The core (master) presents the fetch address and, for loads/stores, the
// data address, store data and request flags. The memory side (slave)
// returns the latched instruction, latched load data and the commit stall.
//   pc    : instruction byte address        (master -> slave)
//   alu   : data byte address (ALU result)  (master -> slave)
//   data  : store data                      (master -> slave)
//   wmem  : store request                   (master -> slave)
//   dreq  : instruction is a load or store  (master -> slave)
//   inst  : latched instruction word        (slave -> master)
//   mem   : latched load data               (slave -> master)
//   stall : 1 = core must not commit        (slave -> master)
interface sccpu_memsys_if;
  logic [31:0] pc;
  logic [31:0] alu;
  logic [31:0] data;
  logic        wmem;
  logic        dreq;
  logic [31:0] inst;
  logic [31:0] mem;
  logic        stall;

  modport master (
    output pc, alu, data, wmem, dreq,
    input  inst, mem, stall
  );

  modport slave (
    input  pc, alu, data, wmem, dreq,
    output inst, mem, stall
  );
endinterface

// File: rtl/sccpu_memsys.sv
// sccpu_memsys
// Memory-side responder for the single-cycle CPU core. One single-port word
// RAM serves both instruction fetch and data load/store; a small FSM
// serialises the two accesses and holds stall high until the single commit
// cycle. A host preload port fills the RAM before (or between) execution.
// Ports:
//   clock   : system clock, rising edge
//   resetn  : asynchronous active-low reset
//   bus     : core bus (slave side), see sccpu_memsys_if
//   ld_en   : host preload write enable, overrides any CPU access
//   ld_addr : host preload word address
//   ld_data : host preload data
// Parameters:
//   ADDR_W  : word-address width, RAM depth 2**ADDR_W words
//   WAIT    : extra wait cycles per RAM access (0..7)
module sccpu_memsys #(
  parameter int ADDR_W = 10,
  parameter int WAIT   = 1
) (
  input  logic              clock,
  input  logic              resetn,
  sccpu_memsys_if.slave     bus,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  typedef enum logic [1:0] {
    S_IF   = 2'd0,
    S_DM   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cnt;
  logic [2:0]        cnt_nxt;
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic [31:0]       inst_q;
  logic [31:0]       mem_q;
  logic [ADDR_W-1:0] pc_idx;
  logic [ADDR_W-1:0] alu_idx;
  logic              last_cycle;
  logic              stall_o;
  logic              fetch_fire;
  logic              load_fire;
  logic              store_fire;
  logic              preload_we;
  logic              unused_addr_bits;

  // Word index: byte offset and bits above the RAM size are dropped, so
  // addresses wrap modulo the RAM depth.
  assign pc_idx     = bus.pc[ADDR_W+1:2];
  assign alu_idx    = bus.alu[ADDR_W+1:2];
  assign last_cycle = (cnt == WAIT_CNT);

  assign unused_addr_bits = ^{bus.pc[31:ADDR_W+2], bus.pc[1:0],
                              bus.alu[31:ADDR_W+2], bus.alu[1:0]};

  // State and wait counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IF;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: preload pins the FSM at the start of a fetch so that a fresh
  // fetch of the current pc begins as soon as ld_en drops.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (ld_en) begin
      state_nxt = S_IF;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IF: begin
          if (last_cycle) begin
            cnt_nxt   = '0;
            state_nxt = bus.dreq ? S_DM : S_DONE;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        S_DM: begin
          if (last_cycle) begin
            cnt_nxt   = '0;
            state_nxt = S_DONE;
          end else begin
            cnt_nxt = cnt + 3'd1;
          end
        end
        S_DONE: begin
          cnt_nxt   = '0;
          state_nxt = S_IF;
        end
        default: begin
          cnt_nxt   = '0;
          state_nxt = S_IF;
        end
      endcase
    end
  end

  // Outputs and RAM strobes. stall decodes the registered state only; the
  // preload write is masked while reset is held.
  always_comb begin
    stall_o    = (state != S_DONE);
    fetch_fire = !ld_en && (state == S_IF) && last_cycle;
    load_fire  = !ld_en && (state == S_DM) && last_cycle && !bus.wmem;
    store_fire = !ld_en && (state == S_DM) && last_cycle && bus.wmem;
    preload_we = ld_en && resetn;
  end

  assign bus.stall = stall_o;
  assign bus.inst  = inst_q;
  assign bus.mem   = mem_q;

  // Latched instruction and load data
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      inst_q <= '0;
      mem_q  <= '0;
    end else begin
      if (fetch_fire) inst_q <= ram[pc_idx];
      if (load_fire)  mem_q  <= ram[alu_idx];
    end
  end

  // Single-port RAM, contents not reset
  always_ff @(posedge clock) begin
    if (preload_we) begin
      ram[ld_addr] <= ld_data;
    end else if (store_fire) begin
      ram[alu_idx] <= bus.data;
    end
  end

endmodule

// File: tb/tb_sccpu_memsys.sv
// tb_sccpu_memsys
// Self-checking bench for sccpu_memsys. Two instances (WAIT=1 and WAIT=0)
// share the clock and preload port; each is exercised while the other is
// held in reset. Expected stall timing, instruction words and load data come
// from an instruction-level model: a word array indexed by (addr/4) mod depth
// plus the per-instruction latency formula.
module tb_sccpu_memsys;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clock = 1'b0;
  logic              resetn_a;
  logic              resetn_b;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [31:0]       ld_data;

  sccpu_memsys_if bus_a ();
  sccpu_memsys_if bus_b ();

  sccpu_memsys #(.ADDR_W(ADDR_W), .WAIT(1)) dut_a (
    .clock   (clock),
    .resetn  (resetn_a),
    .bus     (bus_a),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  sccpu_memsys #(.ADDR_W(ADDR_W), .WAIT(0)) dut_b (
    .clock   (clock),
    .resetn  (resetn_b),
    .bus     (bus_b),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  always #5 clock = ~clock;

  logic [31:0] ref_ram [int];
  logic [31:0] exp_inst;
  logic [31:0] exp_mem;
  int          wait_cyc;
  int          sel;
  int          vectors;
  int          miscompares;

  // Word index of a byte address: drop byte offset, wrap modulo depth.
  function automatic int idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic dutStall();
    return (sel == 1) ? bus_b.stall : bus_a.stall;
  endfunction

  function automatic logic [31:0] dutInst();
    return (sel == 1) ? bus_b.inst : bus_a.inst;
  endfunction

  function automatic logic [31:0] dutMem();
    return (sel == 1) ? bus_b.mem : bus_a.mem;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] stall_exp);
    checkOutput({tag, " stall"}, {31'b0, dutStall()}, stall_exp);
    checkOutput({tag, " inst"}, dutInst(), exp_inst);
    checkOutput({tag, " mem"}, dutMem(), exp_mem);
  endtask

  task automatic driveBus(input logic [31:0] pc_v, input logic [31:0] alu_v,
                          input logic [31:0] data_v, input logic dreq_v, input logic wmem_v);
    if (sel == 1) begin
      bus_b.pc = pc_v; bus_b.alu = alu_v; bus_b.data = data_v;
      bus_b.dreq = dreq_v; bus_b.wmem = wmem_v;
    end else begin
      bus_a.pc = pc_v; bus_a.alu = alu_v; bus_a.data = data_v;
      bus_a.dreq = dreq_v; bus_a.wmem = wmem_v;
    end
  endtask

  // One host preload cycle; stall must stay high and inst/mem must hold.
  task automatic preload(input int a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(a);
    ld_data = d;
    ref_ram[a] = d;
    tick();
    checkAll($sformatf("preload[%0d]", a), 32'd1);
  endtask

  // One whole instruction, starting at the first fetch cycle. Stall is
  // checked every cycle; inst/mem are checked in the commit cycle.
  task automatic applyStimulus(input logic [31:0] pc_v, input logic [31:0] alu_v,
                               input logic [31:0] data_v, input logic dreq_v,
                               input logic wmem_v, input string tag);
    int          lat;
    logic [31:0] fetched;
    lat     = dreq_v ? (2 * wait_cyc + 3) : (wait_cyc + 2);
    fetched = ref_ram[idx(pc_v)];
    driveBus(pc_v, alu_v, data_v, dreq_v, wmem_v);
    for (int k = 1; k <= lat; k++) begin
      checkOutput($sformatf("%s stall c%0d", tag, k), {31'b0, dutStall()},
                  (k == lat) ? 32'd0 : 32'd1);
      if (k < lat) tick();
    end
    exp_inst = fetched;
    if (dreq_v && !wmem_v) exp_mem = ref_ram[idx(alu_v)];
    checkOutput({tag, " inst"}, dutInst(), exp_inst);
    checkOutput({tag, " mem"}, dutMem(), exp_mem);
    if (dreq_v && wmem_v) ref_ram[idx(alu_v)] = data_v;
    tick();
  endtask

  task automatic randomInstrs(input int count, input int base);
    logic [31:0] r;
    logic [31:0] r2;
    logic [31:0] pcw;
    logic [31:0] aluw;
    int          kind;
    for (int n = 0; n < count; n++) begin
      r    = $urandom();
      r2   = $urandom();
      kind = $urandom_range(0, 2);
      pcw  = {r[31:12], 10'(base + $urandom_range(0, 15)), r[1:0]};
      aluw = {r2[31:12], 10'(base + $urandom_range(0, 15)), r2[1:0]};
      applyStimulus(pcw, aluw, $urandom(), kind != 0, kind == 2,
                    $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    sel         = 0;
    wait_cyc    = 1;
    exp_inst    = '0;
    exp_mem     = '0;
    resetn_a    = 1'b0;
    resetn_b    = 1'b0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    sel = 1; driveBus('0, '0, '0, 1'b0, 1'b0);
    sel = 0; driveBus('0, '0, '0, 1'b0, 1'b0);

    // ---------------- WAIT=1 instance ----------------
    tick();
    tick();
    checkAll("reset_a", 32'd1);
    resetn_a = 1'b1;

    preload(0, 32'h2008_0005);
    preload(1, 32'h0000_0000);
    preload(4, 32'hDEAD_BEEF);
    for (int i = 8; i < 24; i++) preload(i, $urandom());
    ld_en = 1'b0;

    // Non-memory instruction twice: 3-cycle stall pattern repeats
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "alu0");
    applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, "alu1");
    // Load, 5 cycles
    applyStimulus(32'h4, 32'h10, 32'h0, 1'b1, 1'b0, "load10");
    // Store then load; mem holds through the store
    applyStimulus(32'h0, 32'h14, 32'h1234_5678, 1'b1, 1'b1, "store14");
    applyStimulus(32'h0, 32'h14, 32'h0, 1'b1, 1'b0, "load14");
    // Address wrap-around and ignored byte offset
    applyStimulus(32'h0, 32'h0000_1004, 32'h0BAD_F00D, 1'b1, 1'b1, "store1004");
    applyStimulus(32'h0, 32'h0000_0004, 32'h0, 1'b1, 1'b0, "load4");
    applyStimulus(32'h0, 32'hFFFF_F007, 32'h0, 1'b1, 1'b0, "load007");
    // Self-modifying code: fetch sees a just-stored word
    applyStimulus(32'h0, 32'h40, 32'hCAFE_F00D, 1'b1, 1'b1, "store40");
    applyStimulus(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, "fetch40");
    // wmem without dreq must not write
    applyStimulus(32'h0, 32'h10, 32'h5555_5555, 1'b0, 1'b1, "wmem_nodreq");
    applyStimulus(32'h0, 32'h10, 32'h0, 1'b1, 1'b0, "load10b");

    randomInstrs(40, 8);

    // Reset during the first S_DM cycle of a store
    applyStimulus(32'h0, 32'h10, 32'h0, 1'b1, 1'b0, "preresetload");
    driveBus(32'h0, 32'h50, 32'hAAAA_AAAA, 1'b1, 1'b1);
    tick();
    tick();
    resetn_a = 1'b0;
    #1;
    exp_inst = '0;
    exp_mem  = '0;
    checkAll("async_reset", 32'd1);
    // Preload attempted while in reset must be ignored
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(20);
    ld_data = 32'h0F0F_0F0F;
    tick();
    ld_en = 1'b0;
    tick();
    checkAll("in_reset", 32'd1);
    resetn_a = 1'b1;
    applyStimulus(32'h0, 32'h50, 32'h0, 1'b1, 1'b0, "load50_after_reset");

    // ---------------- WAIT=0 instance ----------------
    resetn_a = 1'b0;
    sel      = 1;
    wait_cyc = 0;
    ref_ram.delete();
    exp_inst = '0;
    exp_mem  = '0;
    checkAll("reset_b", 32'd1);
    resetn_b = 1'b1;

    preload(0, 32'h0000_0020);
    preload(1, 32'h8C08_0010);
    preload(4, 32'h1357_9BDF);
    for (int i = 32; i < 48; i++) preload(i, $urandom());
    ld_en = 1'b0;

    // Alternating ALU / load: stall 1,0,1,1,0 repeating
    for (int j = 0; j < 3; j++) begin
      applyStimulus(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, $sformatf("b_alu%0d", j));
      applyStimulus(32'h4, 32'h10, 32'h0, 1'b1, 1'b0, $sformatf("b_load%0d", j));
    end
    applyStimulus(32'h0, 32'h1010, 32'h2468_ACE0, 1'b1, 1'b1, "b_store");
    applyStimulus(32'h4, 32'h10, 32'h0, 1'b1, 1'b0, "b_load_after_store");

    randomInstrs(30, 32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
